// File: rtl/mcu_timer.sv
// Memory-mapped prescaled timer with compare-match, auto-reload and interrupt.
// Define TIMER_IRQ_EN to implement the CTRL.IE bit and drive irq; otherwise irq is tied low.
module mcu_timer #(
  parameter int CNT_W = 32,
  parameter int PSC_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wData,
  output logic [31:0] rData,
  output logic        irq
);

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_COUNT  = 2'd1;
  localparam logic [1:0] OFF_CMP    = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  logic             en_q, en_d;
  logic             ar_q, ar_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] cmp_q, cmp_d;
  logic             match_q, match_d;
  logic             ie;

  logic             wr_ctrl, wr_count, wr_cmp, wr_status;
  logic             tick, hit;
  logic [31:0]      ctrl_rd;
  logic             unused_bits;

  assign wr_ctrl   = sel & we & (addr[3:2] == OFF_CTRL);
  assign wr_count  = sel & we & (addr[3:2] == OFF_COUNT);
  assign wr_cmp    = sel & we & (addr[3:2] == OFF_CMP);
  assign wr_status = sel & we & (addr[3:2] == OFF_STATUS);

  assign tick        = en_q & (psc_cnt_q == psc_q);
  assign hit         = (count_q == cmp_q);
  assign unused_bits = ^{addr[31:4], addr[1:0], wData};

  // Later assignments override earlier ones: tick < COUNT write < CLR; a match set beats W1C.
  always_comb begin
    en_d      = en_q;
    ar_d      = ar_q;
    psc_d     = psc_q;
    psc_cnt_d = psc_cnt_q;
    count_d   = count_q;
    cmp_d     = cmp_q;
    match_d   = match_q;

    if (en_q) begin
      psc_cnt_d = tick ? '0 : psc_cnt_q + 1'b1;
    end

    if (tick) begin
      count_d = (hit && ar_q) ? '0 : count_q + 1'b1;
    end

    if (wr_status && wData[0]) begin
      match_d = 1'b0;
    end
    if (tick && hit) begin
      match_d = 1'b1;
    end

    if (wr_cmp) begin
      cmp_d = wData[CNT_W-1:0];
    end

    if (wr_count) begin
      count_d = wData[CNT_W-1:0];
    end

    if (wr_ctrl) begin
      en_d  = wData[0];
      ar_d  = wData[2];
      psc_d = wData[8 +: PSC_W];
      if (wData[1]) begin
        count_d   = '0;
        psc_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q      <= 1'b0;
      ar_q      <= 1'b0;
      psc_q     <= '0;
      psc_cnt_q <= '0;
      count_q   <= '0;
      cmp_q     <= '0;
      match_q   <= 1'b0;
    end else begin
      en_q      <= en_d;
      ar_q      <= ar_d;
      psc_q     <= psc_d;
      psc_cnt_q <= psc_cnt_d;
      count_q   <= count_d;
      cmp_q     <= cmp_d;
      match_q   <= match_d;
    end
  end

`ifdef TIMER_IRQ_EN
  logic ie_q, ie_d;
  logic irq_q, irq_d;

  always_comb begin
    ie_d  = wr_ctrl ? wData[3] : ie_q;
    irq_d = match_q & ie_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie_q  <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie_q  <= ie_d;
      irq_q <= irq_d;
    end
  end

  assign ie  = ie_q;
  assign irq = irq_q;
`else
  assign ie  = 1'b0;
  assign irq = 1'b0;
`endif

  always_comb begin
    ctrl_rd             = '0;
    ctrl_rd[0]          = en_q;
    ctrl_rd[2]          = ar_q;
    ctrl_rd[3]          = ie;
    ctrl_rd[8 +: PSC_W] = psc_q;
  end

  always_comb begin
    rData = '0;
    if (sel) begin
      case (addr[3:2])
        OFF_CTRL:   rData = ctrl_rd;
        OFF_COUNT:  rData = 32'(count_q);
        OFF_CMP:    rData = 32'(cmp_q);
        OFF_STATUS: rData = {31'b0, match_q};
        default:    rData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_timer.sv
// Self-checking bench for mcu_timer: directed scenarios plus randomized bus traffic
// compared against a behavioural register model. Honors TIMER_IRQ_EN like the design.
module tb_mcu_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wData;
  logic [31:0] rData;
  logic        irq;

  int checks = 0;
  int errors = 0;

`ifdef TIMER_IRQ_EN
  localparam bit IRQ_IMPL = 1'b1;
`else
  localparam bit IRQ_IMPL = 1'b0;
`endif

  mcu_timer dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .we    (we),
    .addr  (addr),
    .wData (wData),
    .rData (rData),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  bit          m_en, m_ar, m_ie, m_match, m_irq;
  logic [7:0]  m_psc, m_psc_cnt;
  logic [31:0] m_count, m_cmp;

  task automatic model_reset();
    m_en = 0; m_ar = 0; m_ie = 0; m_match = 0; m_irq = 0;
    m_psc = 8'd0; m_psc_cnt = 8'd0; m_count = 32'd0; m_cmp = 32'd0;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] off);
    case (off)
      2'd0:    return {16'd0, m_psc, 4'd0, m_ie, m_ar, 1'b0, m_en};
      2'd1:    return m_count;
      2'd2:    return m_cmp;
      default: return {31'd0, m_match};
    endcase
  endfunction

  function automatic logic [31:0] make_addr(input logic [1:0] off);
    logic [31:0] r;
    r = $urandom();
    return (r & 32'hFFFF_FFF3) | {28'd0, off, 2'b00};
  endfunction

  // One bus cycle: drive, advance the model by one clock, sample 1 ns after the edge.
  task automatic bus_cycle(input bit s, input bit w, input logic [1:0] off, input logic [31:0] d);
    bit          wr, tick, n_en, n_ar, n_ie, n_match, n_irq;
    logic [7:0]  n_psc, n_psc_cnt;
    logic [31:0] n_count, n_cmp;
    sel = s; we = w; addr = make_addr(off); wData = d;
    wr = s && w;
    tick = m_en && (m_psc_cnt == m_psc);
    n_en = m_en; n_ar = m_ar; n_ie = m_ie; n_psc = m_psc; n_cmp = m_cmp;
    n_psc_cnt = !m_en ? m_psc_cnt : (tick ? 8'd0 : m_psc_cnt + 8'd1);
    n_count = m_count;
    n_match = m_match;
    if (tick) n_count = (m_count == m_cmp && m_ar) ? 32'd0 : m_count + 32'd1;
    if (wr && off == 2'd3 && d[0]) n_match = 0;
    if (tick && m_count == m_cmp) n_match = 1;
    if (wr && off == 2'd2) n_cmp = d;
    if (wr && off == 2'd1) n_count = d;
    if (wr && off == 2'd0) begin
      n_en = d[0]; n_ar = d[2]; n_psc = d[15:8];
      n_ie = d[3] && IRQ_IMPL;
      if (d[1]) begin n_count = 32'd0; n_psc_cnt = 8'd0; end
    end
    n_irq = m_match && m_ie;
    @(posedge clk);
    #1;
    m_en = n_en; m_ar = n_ar; m_ie = n_ie; m_psc = n_psc; m_psc_cnt = n_psc_cnt;
    m_count = n_count; m_cmp = n_cmp; m_match = n_match; m_irq = n_irq;
    sel = 0; we = 0;
  endtask

  task automatic peek(input logic [1:0] off, output logic [31:0] v);
    sel = 1; we = 0; addr = make_addr(off);
    #1;
    v = rData;
    sel = 0;
  endtask

  task automatic reset_dut();
    reset = 1;
    #2;
    reset = 0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    int guard;
    reset = 1; sel = 0; we = 0; addr = 0; wData = 0;
    model_reset();
    #2;
    for (int o = 0; o < 4; o++) begin
      peek(o[1:0], v);
      checks++;
      if (v !== 32'd0) begin
        errors++; $display("[TB] FAIL por_reg%0d got %h expected 00000000", o, v);
      end
    end
    reset = 0;
    @(posedge clk); #1;
    bus_cycle(1, 1, 2'd2, 32'd2);
    bus_cycle(1, 1, 2'd0, 32'h9);
    guard = 0;
    while (m_count != 32'd5 && guard < 20) begin
      bus_cycle(0, 0, 2'd0, 32'd0);
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      errors++; $display("[TB] FAIL reset_setup_timeout got %0d expected <20 cycles", guard);
    end
    peek(2'd1, v);
    checks++;
    if (v !== 32'd5) begin errors++; $display("[TB] FAIL pre_reset_count got %h expected 00000005", v); end
    peek(2'd3, v);
    checks++;
    if (v !== 32'd1) begin errors++; $display("[TB] FAIL pre_reset_match got %h expected 00000001", v); end
    checks++;
    if (irq !== m_irq) begin errors++; $display("[TB] FAIL pre_reset_irq got %b expected %b", irq, m_irq); end
    reset = 1;
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_irq got %b expected 0", irq); end
    for (int o = 0; o < 4; o++) begin
      peek(o[1:0], v);
      checks++;
      if (v !== 32'd0) begin
        errors++; $display("[TB] FAIL async_reset_reg%0d got %h expected 00000000", o, v);
      end
    end
    reset = 0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_auto_reload();
    logic [31:0] v;
    logic [31:0] exp_cnt [4] = '{32'd1, 32'd2, 32'd3, 32'd0};
    logic [31:0] exp_st  [4] = '{32'd0, 32'd0, 32'd0, 32'd1};
    reset_dut();
    bus_cycle(1, 1, 2'd2, 32'd3);
    bus_cycle(1, 1, 2'd0, 32'h5);
    for (int i = 0; i < 4; i++) begin
      bus_cycle(0, 0, 2'd0, 32'd0);
      peek(2'd1, v);
      checks++;
      if (v !== exp_cnt[i]) begin errors++; $display("[TB] FAIL ar_count step%0d got %h expected %h", i, v, exp_cnt[i]); end
      peek(2'd3, v);
      checks++;
      if (v !== exp_st[i]) begin errors++; $display("[TB] FAIL ar_match step%0d got %h expected %h", i, v, exp_st[i]); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("[TB] FAIL ar_irq step%0d got %b expected 0", i, irq); end
    end
  endtask

  task automatic test_prescaler_irq();
    logic [31:0] v;
    reset_dut();
    bus_cycle(1, 1, 2'd2, 32'd1);
    bus_cycle(1, 1, 2'd0, 32'h040D);
    for (int i = 0; i < 16; i++) begin
      bus_cycle(0, 0, 2'd0, 32'd0);
      peek(2'd1, v);
      checks++;
      if (v !== m_count) begin errors++; $display("[TB] FAIL psc_count cyc%0d got %h expected %h", i, v, m_count); end
      peek(2'd3, v);
      checks++;
      if (v !== {31'd0, m_match}) begin errors++; $display("[TB] FAIL psc_match cyc%0d got %h expected %0d", i, v, m_match); end
      checks++;
      if (irq !== m_irq) begin errors++; $display("[TB] FAIL psc_irq cyc%0d got %b expected %b", i, irq, m_irq); end
    end
    checks++;
    if (irq !== IRQ_IMPL) begin errors++; $display("[TB] FAIL psc_irq_final got %b expected %b", irq, IRQ_IMPL); end
    bus_cycle(1, 1, 2'd3, 32'd1);
    bus_cycle(0, 0, 2'd0, 32'd0);
    peek(2'd3, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("[TB] FAIL w1c_match got %h expected 00000000", v); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL w1c_irq got %b expected 0", irq); end
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    int guard;
    reset_dut();
    bus_cycle(1, 1, 2'd1, 32'hFFFF_FFFE);
    bus_cycle(1, 1, 2'd2, 32'h10);
    bus_cycle(1, 1, 2'd0, 32'h1);
    guard = 0;
    while (m_count != 32'h11 && guard < 40) begin
      bus_cycle(0, 0, 2'd0, 32'd0);
      guard++;
      peek(2'd1, v);
      checks++;
      if (v !== m_count) begin errors++; $display("[TB] FAIL wrap_count cyc%0d got %h expected %h", guard, v, m_count); end
      peek(2'd3, v);
      checks++;
      if (v !== {31'd0, m_match}) begin errors++; $display("[TB] FAIL wrap_match cyc%0d got %h expected %0d", guard, v, m_match); end
    end
    peek(2'd1, v);
    checks++;
    if (v !== 32'h11) begin errors++; $display("[TB] FAIL wrap_final_count got %h expected 00000011", v); end
    peek(2'd3, v);
    checks++;
    if (v !== 32'd1) begin errors++; $display("[TB] FAIL wrap_final_match got %h expected 00000001", v); end
  endtask

  task automatic test_collisions();
    logic [31:0] v;
    reset_dut();
    bus_cycle(1, 1, 2'd0, 32'h1);
    bus_cycle(0, 0, 2'd0, 32'd0);
    bus_cycle(1, 1, 2'd1, 32'h100);
    peek(2'd1, v);
    checks++;
    if (v !== 32'h100) begin errors++; $display("[TB] FAIL count_write_on_tick got %h expected 00000100", v); end
    bus_cycle(0, 0, 2'd0, 32'd0);
    peek(2'd1, v);
    checks++;
    if (v !== 32'h101) begin errors++; $display("[TB] FAIL count_after_write got %h expected 00000101", v); end
    bus_cycle(1, 1, 2'd2, 32'd5);
    bus_cycle(1, 1, 2'd1, 32'd5);
    bus_cycle(1, 1, 2'd3, 32'd1);
    peek(2'd3, v);
    checks++;
    if (v !== 32'd1) begin errors++; $display("[TB] FAIL set_beats_w1c got %h expected 00000001", v); end
    peek(2'd1, v);
    checks++;
    if (v !== 32'd6) begin errors++; $display("[TB] FAIL set_cycle_count got %h expected 00000006", v); end
    bus_cycle(1, 1, 2'd0, 32'h3);
    peek(2'd1, v);
    checks++;
    if (v !== 32'd0) begin errors++; $display("[TB] FAIL clr_count got %h expected 00000000", v); end
    peek(2'd0, v);
    checks++;
    if (v !== 32'h1) begin errors++; $display("[TB] FAIL clr_ctrl_read got %h expected 00000001", v); end
  endtask

  task automatic test_bus_isolation();
    logic [31:0] v;
    logic [31:0] d;
    logic [31:0] exp_regs [4] = '{32'h0, 32'h42, 32'h7, 32'h0};
    reset_dut();
    bus_cycle(1, 1, 2'd2, 32'h7);
    bus_cycle(1, 1, 2'd1, 32'h42);
    for (int i = 0; i < 8; i++) begin
      d = $urandom();
      bus_cycle(0, 1, i[1:0], d | 32'h1);
      sel = 0; addr = make_addr(i[1:0]);
      #1;
      checks++;
      if (rData !== 32'd0) begin errors++; $display("[TB] FAIL unselected_rdata got %h expected 00000000", rData); end
    end
    for (int o = 0; o < 4; o++) begin
      peek(o[1:0], v);
      checks++;
      if (v !== exp_regs[o]) begin errors++; $display("[TB] FAIL isolation_reg%0d got %h expected %h", o, v, exp_regs[o]); end
    end
    bus_cycle(1, 1, 2'd0, 32'h8);
    peek(2'd0, v);
    checks++;
    if (v !== {28'd0, IRQ_IMPL, 3'd0}) begin errors++; $display("[TB] FAIL ie_readback got %h expected %h", v, {28'd0, IRQ_IMPL, 3'd0}); end
    bus_cycle(1, 1, 2'd2, 32'h0);
    bus_cycle(1, 1, 2'd1, 32'h0);
    bus_cycle(1, 1, 2'd0, 32'h9);
    for (int i = 0; i < 3; i++) bus_cycle(0, 0, 2'd0, 32'd0);
    checks++;
    if (irq !== IRQ_IMPL) begin errors++; $display("[TB] FAIL irq_build_option got %b expected %b", irq, IRQ_IMPL); end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [31:0] d;
    int r;
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 11);
      d = $urandom();
      case (r)
        0: bus_cycle(1, 1, 2'd0, {16'd0, 6'd0, d[9:8], 4'd0, d[3:2], (d[4:1] == 4'd0), 1'b1});
        1: bus_cycle(1, 1, 2'd0, {16'd0, 6'd0, d[9:8], 4'd0, d[3:0]});
        2: bus_cycle(1, 1, 2'd1, (d[0] ? 32'hFFFF_FFF0 : 32'd0) | {28'd0, d[7:4]});
        3: bus_cycle(1, 1, 2'd2, {28'd0, d[3:0]});
        4: bus_cycle(1, 1, 2'd3, d);
        5: bus_cycle(0, 1, d[1:0], $urandom());
        6: bus_cycle(1, 0, d[1:0], $urandom());
        default: bus_cycle(0, 0, 2'd0, 32'd0);
      endcase
      for (int o = 0; o < 4; o++) begin
        peek(o[1:0], v);
        checks++;
        if (v !== model_read(o[1:0])) begin
          errors++; $display("[TB] FAIL rand_reg%0d cyc%0d got %h expected %h", o, i, v, model_read(o[1:0]));
        end
      end
      checks++;
      if (irq !== m_irq) begin errors++; $display("[TB] FAIL rand_irq cyc%0d got %b expected %b", i, irq, m_irq); end
    end
  endtask

  initial begin
    test_reset();
    test_auto_reload();
    test_prescaler_irq();
    test_wrap();
    test_collisions();
    test_bus_isolation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
